// File: rtl/pwm_bank_if.sv
// Command and pin bus of the multi-channel PWM block.
interface pwm_bank_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: strobed commands, prescaler, double-buffered duty, enable mask.
module pwm_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ena,
    pwm_bank_if.slave bus
);

    localparam int unsigned      MAX      = (1 << WIDTH) - 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MAX - 1);
    localparam logic [1:0]       OP_DUTY  = 2'b01;
    localparam logic [1:0]       OP_PRE   = 2'b10;
    localparam logic [1:0]       OP_MASK  = 2'b11;

    logic                          prev_strobe_q, prev_strobe_d;
    logic [7:0]                    pre_q, pre_d;
    logic [7:0]                    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]              cnt_q, cnt_d;
    logic [NUM_CH-1:0]             mask_q, mask_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0][WIDTH-1:0]  active_q, active_d;
    logic [NUM_CH-1:0]             pwm_q, pwm_d;
    logic                          wrap_q, wrap_d;

    logic       accept_c;
    logic       tick_c;
    logic       boundary_c;
    logic [7:0] uo_c;
    logic       unused_bits_c;

    // Strobe edge detect, prescaler tick and period boundary.
    always_comb begin
        accept_c   = bus.ui_in[7] & ~prev_strobe_q;
        tick_c     = ena & (pre_cnt_q == pre_q);
        boundary_c = tick_c & (cnt_q == CNT_LAST);
    end

    // Command decode into shadow duty, prescale and mask registers.
    always_comb begin
        prev_strobe_d = bus.ui_in[7];
        pre_d         = pre_q;
        mask_d        = mask_q;
        shadow_d      = shadow_q;
        if (accept_c) begin
            case (bus.ui_in[6:5])
                OP_DUTY: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (bus.ui_in[2:0] == 3'(i)) begin
                            shadow_d[i] = bus.uio_in[WIDTH-1:0];
                        end
                    end
                end
                OP_PRE:  pre_d  = bus.uio_in;
                OP_MASK: mask_d = bus.uio_in[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    // Prescaler, period counter, duty buffer swap and output compare.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        pwm_d     = pwm_q;
        active_d  = boundary_c ? shadow_q : active_q;
        wrap_d    = boundary_c;
        if (ena) begin
            pre_cnt_d = tick_c ? 8'd0 : pre_cnt_q + 8'd1;
            if (tick_c) begin
                cnt_d = boundary_c ? '0 : cnt_q + WIDTH'(1);
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pwm_d[i] = mask_q[i] & (cnt_q < active_q[i]);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_strobe_q <= 1'b1;
            pre_q         <= '0;
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            pwm_q         <= '0;
            wrap_q        <= 1'b0;
        end else begin
            prev_strobe_q <= prev_strobe_d;
            pre_q         <= pre_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pwm_q         <= pwm_d;
            wrap_q        <= wrap_d;
        end
    end

    // Pin mapping: PWM lanes low, wrap pulse on bit 7, unused lanes tied low.
    always_comb begin
        uo_c             = '0;
        uo_c[NUM_CH-1:0] = pwm_q;
        uo_c[7]          = wrap_q;
    end

    assign bus.uo_out  = uo_c;
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;

    // ui_in[4:3] carry no meaning.
    assign unused_bits_c = ^bus.ui_in[4:3];

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator in the team's standard user-project pin envelope.
- It is driven entirely through ui_in and uio_in, and its waveforms are presented on uo_out.
- It generalises the single-project top to NUM_CH channels of WIDTH-bit resolution.
- New behaviour: a command strobe interface, a programmable prescaler, double-buffered duty registers and a per-channel enable mask.

Parameters:
- NUM_CH, 4, number of PWM channels; legal range 1..7.
- WIDTH, 8, counter/duty resolution in bits; legal range 2..8; duty is taken from uio_in[WIDTH-1:0].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  design enable; when low the prescaler and counter freeze.
- ui_in  in  8  command bus: [7] strobe, [6:5] opcode, [2:0] channel select.
- uio_in  in  8  command data.
- uo_out  out  8  [NUM_CH-1:0] PWM outputs; [6:NUM_CH] always 0; [7] period-wrap pulse.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0; all uio pins are inputs.

Behaviour:
- Single clock; every register is updated on the rising edge of clk.
- Reset (rst_n=0 at an edge) clears shadow[], active[], mask, PRE, pre_cnt, cnt, uo_out and the pwm registers; prev_strobe is set to 1.
- Reset mid-operation takes effect at the next edge; it has no partial effect.
- MAX = 2^WIDTH-1.
- Command accept: on the cycle where ui_in[7]=1 and prev_strobe=0. prev_strobe <= ui_in[7] every cycle.
  - Because prev_strobe resets to 1, a strobe held high across reset release is not accepted.
  - Commands are accepted regardless of ena.
- Opcode 00: no operation.
- Opcode 01: shadow[ui_in[2:0]] <= uio_in[WIDTH-1:0]. Ignored if ui_in[2:0] >= NUM_CH.
- Opcode 10: PRE <= uio_in.
- Opcode 11: mask <= uio_in[NUM_CH-1:0]; higher bits are discarded.
- Prescaler: when ena=1 it generates tick when pre_cnt==PRE.
  - On tick, pre_cnt <= 0; otherwise pre_cnt increments.
  - The counter therefore advances every PRE+1 cycles. A PRE write takes effect immediately; if pre_cnt > new PRE, pre_cnt wraps through 255 to 0.
- Counter: on tick, cnt runs 0..MAX-1 and then wraps to 0. The period is MAX ticks (255 for WIDTH=8).
- Period boundary: a tick while cnt==MAX-1.
  - At the boundary, active[i] <= shadow[i] for all i, and the wrap register (uo_out[7]) is 1 for the following cycle only.
  - A shadow write in the same cycle as a boundary does not reach active until the next boundary; active loads the pre-write value.
- Output: pwm[i] <= mask[i] & (cnt < active[i]); this is registered, one cycle after cnt.
  - active=0 gives constant 0.
  - active=MAX gives constant 1.
- ena=0: pre_cnt, cnt and pwm hold; no boundary occurs. Resuming with ena=1 continues from the held state.

Test Plan:
- WIDTH=8, NUM_CH=4, PRE=0 written, opcode 01 ch0 data 64, opcode 11 data 0x01 -> after the first uo_out[7] pulse, uo_out[0] is high for 64 cycles and low for 191 per 255-cycle period; uo_out[3:1]=0 and uo_out[6:4]=0.
- ch1 duty 0 and ch2 duty 255, mask 0x07 -> after a boundary uo_out[1] is constantly 0 and uo_out[2] is constantly 1 across 3 periods.
- PRE=3 with ch0 duty 128 -> uo_out[7] pulses every 1020 cycles; uo_out[0] is high for 512 cycles per period.
- ch0 running at duty 64; write duty 200 at cnt=100 -> the current period stays 64-high; the next period (after the uo_out[7] pulse) is 200-high.
- Hold ui_in[7]=1 from reset through release with opcode 01 ch0 data 50 -> shadow[0] stays 0. Write ch5 data 99 with a proper strobe edge -> no state changes, and uio_oe=0x00 and uio_out=0x00 throughout.
- Drop ena to 0 for 37 cycles mid-period -> cnt and outputs freeze and the period lengthens by 37 cycles. Assert rst_n=0 mid-period -> uo_out=0x00 one edge later, and the duty must be rewritten.
